infer_sdiv_35s_21s_14_seq: RTL and testbench

- Sequential signed divider; the arithmetic inverse of the pipelined 14s×21s→35 multiplier used in the infer datapath.
- Recovers a 14-bit signed factor from a 35-bit signed product and a 21-bit signed divisor.
- Radix-2 restoring core, one quotient bit per enabled cycle; start/ready/done handshake; shares the multiplier's `ce` stall convention.
- Sits in the infer core wherever scaled accumulators are normalised back to activation width.

---
 rtl/infer_sdiv_35s_21s_14_seq.sv | 147 ++++++++++++++
 tb/tb_infer_sdiv_35s_21s_14_seq.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/infer_sdiv_35s_21s_14_seq.sv
// Sequential signed divider: 35-bit dividend / 21-bit divisor -> saturated 14-bit quotient plus remainder.
// Radix-2 restoring core producing one quotient bit per enabled cycle, with a start/ready/done handshake.
module infer_sdiv_35s_21s_14_seq #(
    parameter int din0_WIDTH = 35,
    parameter int din1_WIDTH = 21,
    parameter int dout_WIDTH = 14
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  start,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  ready,
    output logic                  done,
    output logic [dout_WIDTH-1:0] dout,
    output logic [din1_WIDTH-1:0] rem,
    output logic                  div0,
    output logic                  ovf
);

    localparam int CW = $clog2(din0_WIDTH);
    localparam logic signed [din0_WIDTH:0] QMAX =
        (din0_WIDTH+1)'((longint'(1) << (dout_WIDTH-1)) - 1);
    localparam logic signed [din0_WIDTH:0] QMIN = ~QMAX;

    typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

    state_t                  state, next_state;
    logic [din0_WIDTH-1:0]   dvd;
    logic [din1_WIDTH-1:0]   dvs;
    logic [din1_WIDTH-1:0]   pr;
    logic [din0_WIDTH-1:0]   quo;
    logic [CW-1:0]           cnt;
    logic                    sign_q;
    logic                    sign_r;
    logic                    zero_flag;

    logic [din0_WIDTH-1:0]   din0_abs;
    logic [din1_WIDTH-1:0]   din1_abs;
    logic [din1_WIDTH:0]     pr_shift;
    logic [din1_WIDTH-1:0]   pr_sub;
    logic                    q_bit;
    logic signed [din0_WIDTH:0] q_signed;
    logic [dout_WIDTH-1:0]   q_sat;
    logic                    sat_flag;
    logic [din1_WIDTH-1:0]   rem_fix;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else if (ce)
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = CALC;
            CALC:    if (cnt == '0) next_state = FIXUP;
            FIXUP:   next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign ready = (state == IDLE);
    assign done  = (state == DONE);

    // Magnitudes are held unsigned, so the most negative operands still fit without overflow.
    always_comb begin
        din0_abs = din0[din0_WIDTH-1] ? -din0 : din0;
        din1_abs = din1[din1_WIDTH-1] ? -din1 : din1;
        pr_shift = {pr, dvd[din0_WIDTH-1]};
        pr_sub   = pr_shift[din1_WIDTH-1:0] - dvs;
        q_bit    = (pr_shift >= {1'b0, dvs});
    end

    always_comb begin
        q_signed = sign_q ? -$signed({1'b0, quo}) : $signed({1'b0, quo});
        q_sat    = q_signed[dout_WIDTH-1:0];
        sat_flag = 1'b0;
        if (q_signed > QMAX) begin
            q_sat    = {1'b0, {(dout_WIDTH-1){1'b1}}};
            sat_flag = 1'b1;
        end else if (q_signed < QMIN) begin
            q_sat    = {1'b1, {(dout_WIDTH-1){1'b0}}};
            sat_flag = 1'b1;
        end
        rem_fix = sign_r ? -pr : pr;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dvd       <= '0;
            dvs       <= '0;
            pr        <= '0;
            quo       <= '0;
            cnt       <= '0;
            sign_q    <= 1'b0;
            sign_r    <= 1'b0;
            zero_flag <= 1'b0;
            dout      <= '0;
            rem       <= '0;
            div0      <= 1'b0;
            ovf       <= 1'b0;
        end else if (ce) begin
            case (state)
                IDLE: begin
                    if (start) begin
                        dvd       <= din0_abs;
                        dvs       <= din1_abs;
                        sign_q    <= din0[din0_WIDTH-1] ^ din1[din1_WIDTH-1];
                        sign_r    <= din0[din0_WIDTH-1];
                        zero_flag <= (din1 == '0);
                        cnt       <= CW'(din0_WIDTH-1);
                        pr        <= '0;
                        quo       <= '0;
                    end
                end
                CALC: begin
                    dvd <= {dvd[din0_WIDTH-2:0], 1'b0};
                    pr  <= q_bit ? pr_sub : pr_shift[din1_WIDTH-1:0];
                    quo <= {quo[din0_WIDTH-2:0], q_bit};
                    if (cnt != '0)
                        cnt <= cnt - 1'b1;
                end
                FIXUP: begin
                    // A zero divisor still runs the core; its result is simply overridden here.
                    if (zero_flag) begin
                        dout <= '0;
                        rem  <= '0;
                        div0 <= 1'b1;
                        ovf  <= 1'b0;
                    end else begin
                        dout <= q_sat;
                        rem  <= rem_fix;
                        div0 <= 1'b0;
                        ovf  <= sat_flag;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_infer_sdiv_35s_21s_14_seq.sv
// Self-checking bench for infer_sdiv_35s_21s_14_seq: directed vector table, stall/reset sequences,
// and randomized operands compared against a plain-arithmetic reference model.
module tb_infer_sdiv_35s_21s_14_seq;

    logic               clk;
    logic               reset;
    logic               ce;
    logic               start;
    logic signed [34:0] din0;
    logic signed [20:0] din1;
    logic               ready;
    logic               done;
    logic signed [13:0] dout;
    logic signed [20:0] rem;
    logic               div0;
    logic               ovf;

    int checks   = 0;
    int failures = 0;

    infer_sdiv_35s_21s_14_seq dut (
        .clk   (clk),
        .reset (reset),
        .ce    (ce),
        .start (start),
        .din0  (din0),
        .din1  (din1),
        .ready (ready),
        .done  (done),
        .dout  (dout),
        .rem   (rem),
        .div0  (div0),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        longint a;
        longint b;
        longint expQ;
        longint expR;
        bit     expDiv0;
        bit     expOvf;
    } vec_t;

    task automatic checkOutput(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: truncating signed division on 64-bit integers, then saturation / zero-divisor rules.
    function automatic void refModel(input longint a, input longint b,
                                     output longint q, output longint r,
                                     output bit d0, output bit ov);
        longint qf;
        d0 = 1'b0;
        ov = 1'b0;
        if (b == 0) begin
            q  = 0;
            r  = 0;
            d0 = 1'b1;
        end else begin
            qf = a / b;
            r  = a % b;
            q  = qf;
            if (qf > 8191) begin
                q  = 8191;
                ov = 1'b1;
            end else if (qf < -8192) begin
                q  = -8192;
                ov = 1'b1;
            end
        end
    endfunction

    // Waits for ready, issues one start, and counts enabled edges (accept edge included) until done.
    task automatic applyStimulus(input longint a, input longint b, output int lat, output bit readyBad);
        int guard;
        logic [63:0] av;
        logic [63:0] bv;
        av = a;
        bv = b;
        readyBad = 1'b0;
        guard = 0;
        @(negedge clk);
        while (!ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        din0  = av[34:0];
        din1  = bv[20:0];
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 1;
        while (!done && lat < 200) begin
            if (ready) readyBad = 1'b1;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic checkResult(input string tag, input longint q, input longint r,
                               input bit d0, input bit ov);
        checkOutput({tag, ".dout"}, longint'(dout), q);
        checkOutput({tag, ".rem"},  longint'(rem),  r);
        checkOutput({tag, ".div0"}, longint'(div0), longint'(d0));
        checkOutput({tag, ".ovf"},  longint'(ovf),  longint'(ov));
    endtask

    vec_t vecs[$];

    initial begin
        int lat;
        bit rb;
        int e;
        longint q, r;
        bit d0, ov;
        logic [63:0] r64;
        logic signed [34:0] ra;
        logic signed [20:0] rbv;
        longint a, b;

        vecs.push_back('{1000, 7, 142, 6, 0, 0});
        vecs.push_back('{-1000, 7, -142, -6, 0, 0});
        vecs.push_back('{1000, -7, -142, 6, 0, 0});
        vecs.push_back('{-1000, -7, 142, -6, 0, 0});
        vecs.push_back('{12345, 0, 0, 0, 1, 0});
        vecs.push_back('{10, 3, 3, 1, 0, 0});
        vecs.push_back('{100000, 1, 8191, 0, 0, 1});
        vecs.push_back('{-(longint'(1) << 34), 1, -8192, 0, 0, 1});
        vecs.push_back('{-8192, 1, -8192, 0, 0, 0});
        vecs.push_back('{-(longint'(1) << 34), -(longint'(1) << 20), 8191, 0, 0, 1});
        vecs.push_back('{77, -5, -15, 2, 0, 0});

        ce    = 1'b1;
        start = 1'b0;
        din0  = '0;
        din1  = '0;
        reset = 1'b1;
        #12;
        checkOutput("reset.ready", longint'(ready), 1);
        checkOutput("reset.done",  longint'(done), 0);
        checkResult("reset", 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            applyStimulus(vecs[i].a, vecs[i].b, lat, rb);
            checkOutput({tag, ".latency"}, lat, 37);
            checkOutput({tag, ".readyLow"}, longint'(rb), 0);
            checkResult(tag, vecs[i].expQ, vecs[i].expR, vecs[i].expDiv0, vecs[i].expOvf);
        end

        // Stall sequence: ce low on edges 12..16 during CALC, a start pulse while busy, then done held under ce=0.
        @(negedge clk);
        while (!ready) @(negedge clk);
        din0  = 35'sd1000;
        din1  = 21'sd7;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        e = 1;
        while (!done && e < 200) begin
            e++;
            @(negedge clk);
            ce    = (e >= 12 && e <= 16) ? 1'b0 : 1'b1;
            start = (e == 14);
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        checkOutput("stall.doneEdge", e, 42);
        checkResult("stall", 142, 6, 0, 0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            ce = 1'b0;
            @(posedge clk);
            #1;
            checkOutput("stall.doneHeld", longint'(done), 1);
            checkOutput("stall.doutHeld", longint'(dout), 142);
        end
        @(negedge clk);
        ce = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("stall.doneDrop", longint'(done), 0);
        checkOutput("stall.readyBack", longint'(ready), 1);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("stall.noQueuedStart", longint'(ready), 1);

        // Asynchronous reset in the middle of CALC.
        @(negedge clk);
        din0  = 35'sd1000;
        din1  = 21'sd7;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("asyncReset.ready", longint'(ready), 1);
        checkOutput("asyncReset.done",  longint'(done), 0);
        checkResult("asyncReset", 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(77, -5, lat, rb);
        checkOutput("afterReset.latency", lat, 37);
        checkResult("afterReset", -15, 2, 0, 0);

        // Randomized operands against the reference model.
        for (int n = 0; n < 60; n++) begin
            r64 = {$urandom(), $urandom()};
            ra  = r64[34:0];
            r64 = {$urandom(), $urandom()};
            rbv = r64[20:0];
            a = longint'(ra);
            b = longint'(rbv);
            case (n % 3)
                1: a = a >>> 12;
                2: begin
                    a = a >>> 20;
                    b = longint'($urandom_range(0, 6)) - 3;
                end
                default: ;
            endcase
            refModel(a, b, q, r, d0, ov);
            applyStimulus(a, b, lat, rb);
            checkOutput($sformatf("rand%0d.latency", n), lat, 37);
            checkResult($sformatf("rand%0d(%0d/%0d)", n, a, b), q, r, d0, ov);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
